fsm_seq_monitor: RTL and testbench

//  Receive-side checker for the 2-bit cyclic state code (0->1->2->3->0) the

---
 rtl/fsm_seq_monitor_if.sv | 16 +
 rtl/fsm_seq_monitor.sv | 132 +++++++++++++
 tb/tb_fsm_seq_monitor.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_monitor_if.sv
// Sample bus from the sequencer into its monitor.
// Master drives a code qualified by a valid strobe.
interface fsm_seq_monitor_if;
  logic       in_valid;
  logic [2:0] in_code;

  modport master (
    output in_valid,
    output in_code
  );

  modport slave (
    input in_valid,
    input in_code
  );
endinterface

// File: rtl/fsm_seq_monitor.sv
// Receive-side checker for the 0->1->2->3 cyclic sequencer code.
// Optional FSM_MON_HOLD_EN: accept a repeated code as a hold in TRACK.
module fsm_seq_monitor #(
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  fsm_seq_monitor_if.slave in_if,
  input  logic             clr,
  output logic             locked,
  output logic             lap_pulse,
  output logic             err_pulse,
  output logic             err_flag,
  output logic [CNT_W-1:0] lap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam logic [3:0] LIM = 4'(ERR_LIMIT);

  state_e           state_q, state_d;
  logic [1:0]       exp_q, exp_d;
  logic [3:0]       consec_q, consec_d;
  logic [CNT_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             lap_pulse_q, lap_pulse_d;
  logic             err_pulse_q, err_pulse_d;

  logic       code_ok;
  logic       hold_ok;
  logic [3:0] consec_inc;

  assign code_ok    = !in_if.in_code[2] &&
                      (in_if.in_code[1:0] == exp_q);
  assign consec_inc = consec_q + 4'd1;

`ifdef FSM_MON_HOLD_EN
  assign hold_ok = !in_if.in_code[2] &&
                   (in_if.in_code[1:0] == exp_q - 2'd1);
`else
  assign hold_ok = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    consec_d    = consec_q;
    lap_cnt_d   = lap_cnt_q;
    err_cnt_d   = err_cnt_q;
    lap_pulse_d = 1'b0;
    err_pulse_d = 1'b0;

    if (clr) begin
      state_d   = HUNT;
      exp_d     = 2'd0;
      consec_d  = 4'd0;
      lap_cnt_d = '0;
      err_cnt_d = '0;
    end else if (in_if.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_if.in_code == 3'd0) begin
            state_d = TRACK;
            exp_d   = 2'd1;
          end
        end
        TRACK: begin
          if (code_ok) begin
            exp_d    = exp_q + 2'd1;
            consec_d = 4'd0;
            if (exp_q == 2'd3) begin
              lap_pulse_d = 1'b1;
              if (!(&lap_cnt_q))
                lap_cnt_d = lap_cnt_q + 1'b1;
            end
          end else if (hold_ok) begin
            consec_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            consec_d    = consec_inc;
            if (!(&err_cnt_q))
              err_cnt_d = err_cnt_q + 1'b1;
            if (consec_inc >= LIM)
              state_d = ERROR;
            else if (!in_if.in_code[2])
              exp_d = in_if.in_code[1:0] + 2'd1;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= 2'd0;
      consec_q    <= 4'd0;
      lap_cnt_q   <= '0;
      err_cnt_q   <= '0;
      lap_pulse_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      consec_q    <= consec_d;
      lap_cnt_q   <= lap_cnt_d;
      err_cnt_q   <= err_cnt_d;
      lap_pulse_q <= lap_pulse_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == TRACK);
  assign err_flag  = (state_q == ERROR);
  assign lap_pulse = lap_pulse_q;
  assign err_pulse = err_pulse_q;
  assign lap_cnt   = lap_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor: 8-bit and 2-bit counter builds
// driven in lockstep, outputs checked against a queued reference.
module tb_fsm_seq_monitor;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  fsm_seq_monitor_if ifa ();
  fsm_seq_monitor_if ifb ();

  logic       a_locked, a_lp, a_ep, a_ef;
  logic [7:0] a_lap, a_err;
  logic       b_locked, b_lp, b_ep, b_ef;
  logic [1:0] b_lap, b_err;

  fsm_seq_monitor #(.ERR_LIMIT(3), .CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_if     (ifa.slave),
    .clr       (clr),
    .locked    (a_locked),
    .lap_pulse (a_lp),
    .err_pulse (a_ep),
    .err_flag  (a_ef),
    .lap_cnt   (a_lap),
    .err_cnt   (a_err)
  );

  fsm_seq_monitor #(.ERR_LIMIT(3), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_if     (ifb.slave),
    .clr       (clr),
    .locked    (b_locked),
    .lap_pulse (b_lp),
    .err_pulse (b_ep),
    .err_flag  (b_ef),
    .lap_cnt   (b_lap),
    .err_cnt   (b_err)
  );

  typedef struct packed {
    logic [19:0] a;
    logic [7:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_step = 0;

  // reference state: 0 hunt, 1 track, 2 error
  int m_st, m_exp, m_con, m_lap, m_err;
  bit m_lp, m_ep;

  function automatic void m_reset();
    m_st = 0; m_exp = 0; m_con = 0;
    m_lap = 0; m_err = 0; m_lp = 0; m_ep = 0;
  endfunction

  function automatic void m_step(bit v, logic [2:0] c, bit cl);
    bit hold;
    m_lp = 0;
    m_ep = 0;
    if (cl) begin
      m_st = 0; m_exp = 0; m_con = 0; m_lap = 0; m_err = 0;
    end else if (v) begin
      if (m_st == 0) begin
        if (c == 3'd0) begin
          m_st = 1; m_exp = 1;
        end
      end else if (m_st == 1) begin
`ifdef FSM_MON_HOLD_EN
        hold = (c[2] == 1'b0) && (int'(c[1:0]) == (m_exp + 3) % 4);
`else
        hold = 0;
`endif
        if (c[2] == 1'b0 && int'(c[1:0]) == m_exp) begin
          m_con = 0;
          if (m_exp == 3) begin
            m_lap = m_lap + 1; m_lp = 1;
          end
          m_exp = (m_exp + 1) % 4;
        end else if (hold) begin
          m_con = 0;
        end else begin
          m_ep = 1; m_err = m_err + 1; m_con = m_con + 1;
          if (m_con >= 3) m_st = 2;
          else if (c[2] == 1'b0) m_exp = (int'(c[1:0]) + 1) % 4;
        end
      end
    end
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    int la, ea, lb, eb;
    la = (m_lap > 255) ? 255 : m_lap;
    ea = (m_err > 255) ? 255 : m_err;
    lb = (m_lap > 3) ? 3 : m_lap;
    eb = (m_err > 3) ? 3 : m_err;
    e.a = {m_st == 1, m_lp, m_ep, m_st == 2, 8'(la), 8'(ea)};
    e.b = {m_st == 1, m_lp, m_ep, m_st == 2, 2'(lb), 2'(eb)};
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [19:0] oa;
    logic [7:0]  ob;
    n_chk++;
    assert (exp_q.size() != 0) n_pass++;
    else $error("FAIL scoreboard_empty step=%0d got=0 want=1", n_step);
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      oa = {a_locked, a_lp, a_ep, a_ef, a_lap, a_err};
      ob = {b_locked, b_lp, b_ep, b_ef, b_lap, b_err};
      n_chk++;
      assert (oa === e.a) n_pass++;
      else $error("FAIL out_w8 step=%0d got=%h want=%h",
                  n_step, oa, e.a);
      n_chk++;
      assert (ob === e.b) n_pass++;
      else $error("FAIL out_w2 step=%0d got=%h want=%h",
                  n_step, ob, e.b);
    end
  endtask

  task automatic chk(string tag, int obs, int want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s got=%0d want=%0d", tag, obs, want);
  endtask

  task automatic step(bit v, logic [2:0] c, bit cl);
    @(negedge clk);
    ifa.in_valid = v; ifa.in_code = c;
    ifb.in_valid = v; ifb.in_code = c;
    clr = cl;
    m_step(v, c, cl);
    exp_q.push_back(m_out());
    @(posedge clk);
    #1;
    n_step++;
    check_pop();
  endtask

  task automatic send(logic [2:0] c);
    step(1'b1, c, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_code = 3'd0;
    ifb.in_valid = 1'b0; ifb.in_code = 3'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(m_out());
    check_pop();
    chk("reset_locked", int'(a_locked), 0);
    @(negedge clk);
    rst = 1'b0;

    // lock and run two laps; idle samples in between are ignored
    send(3'd5);
    send(3'd2);
    send(3'd0);
    chk("lock_after_0", int'(a_locked), 1);
    for (int i = 1; i < 8; i++) begin
      send(3'(i % 4));
      if (i == 3) step(1'b0, 3'd3, 1'b0);
    end
    chk("laps_2", int'(a_lap), 2);
    chk("no_err", int'(a_err), 0);

    // 0,1,3: error on 3 then resync to 0
    send(3'd0);
    send(3'd1);
    send(3'd3);
    chk("err_pulse_on_3", int'(a_ep), 1);
    chk("err_cnt_1", int'(a_err), 1);
    send(3'd0);
    chk("resync_locked", int'(a_locked), 1);
    chk("resync_no_err", int'(a_ep), 0);

    // bit2 set: error, expect unchanged, next code accepted
    send(3'b100);
    chk("bit2_err", int'(a_ep), 1);
    send(3'd1);
    chk("bit2_then_ok", int'(a_ep), 0);
    send(3'd2);

    // three consecutive faults -> ERROR, then clr
    step(1'b0, 3'd0, 1'b1);
    chk("clr_cnt", int'(a_err), 0);
    send(3'd0);
    send(3'b100);
    send(3'b100);
    send(3'b110);
    chk("error_flag", int'(a_ef), 1);
    chk("error_unlock", int'(a_locked), 0);
    chk("error_cnt_3", int'(a_err), 3);
    send(3'd3);
    send(3'd0);
    send(3'd1);
    chk("error_sticky", int'(a_ef), 1);
    step(1'b0, 3'd0, 1'b1);
    chk("error_cleared", int'(a_ef), 0);

    // five laps: 2-bit counter saturates at 3
    send(3'd0);
    for (int l = 0; l < 5; l++)
      for (int i = 1; i < 5; i++)
        send(3'(i % 4));
    chk("laps_w8_5", int'(a_lap), 5);
    chk("laps_w2_sat", int'(b_lap), 3);
    step(1'b1, 3'd0, 1'b1);
    chk("clr_drop_lock", int'(a_locked), 0);
    chk("clr_lap0", int'(b_lap), 0);

    // repeated value: hold or error depending on build
    send(3'd0);
    send(3'd1);
    send(3'd1);
    send(3'd2);
    chk("repeat_locked", int'(a_locked), 1);
`ifdef FSM_MON_HOLD_EN
    chk("repeat_err", int'(a_err), 0);
`else
    chk("repeat_err", int'(a_err), 1);
`endif

    // mid-run async reset
    send(3'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    exp_q.push_back(m_out());
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    send(3'd1);
    send(3'd0);
    chk("relock_after_rst", int'(a_locked), 1);
    step(1'b0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
